// File: rtl/max_tracker_2b_if.sv
// Stream interface for max_tracker_2b: sample input channel and report output channel.
// The slave modport is the tracker side; the master modport is the producer/consumer side.
// Optional index output is present only when MAX_TRACKER_INDEX_EN is defined.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1.
// A source holds valid and its payload stable until that edge; ready never depends on
// valid in this block, and valid never depends on ready.
interface max_tracker_2b_if #(
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_max;
  logic [CNT_W-1:0] out_rises;
`ifdef MAX_TRACKER_INDEX_EN
  logic [CNT_W-1:0] out_idx;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef MAX_TRACKER_INDEX_EN
    output out_idx,
`endif
    output in_ready, out_valid, out_max, out_rises
  );

  modport master (
    output in_valid, in_data, out_ready,
`ifdef MAX_TRACKER_INDEX_EN
    input  out_idx,
`endif
    input  in_ready, out_valid, out_max, out_rises
  );
endinterface

// File: rtl/max_tracker_2b.sv
// Windowed running-maximum tracker for 2-bit samples. Each window of WINDOW samples
// produces one report (maximum, count of strict rises) on a valid/ready channel.
// Optional macro MAX_TRACKER_INDEX_EN adds out_idx, the position of the first maximum.
module max_tracker_2b #(
  parameter int WINDOW = 4,
  parameter int CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  max_tracker_2b_if.slave      bus,
  output logic [1:0]           state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rises_q, rises_d;
  logic [1:0]       out_max_q, out_max_d;
  logic [CNT_W-1:0] out_rises_q, out_rises_d;
`ifdef MAX_TRACKER_INDEX_EN
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] out_idx_q, out_idx_d;
`endif

  logic accept;
  logic gt;
  logic a, b, c, d;

  // Comparator equation: sample (A,B) strictly greater than stored max (C,D).
  assign a  = bus.in_data[1];
  assign b  = bus.in_data[0];
  assign c  = max_q[1];
  assign d  = max_q[0];
  assign gt = (a & ~c) | (a & b & ~d) | (b & ~c & ~d);

  assign bus.in_ready  = (state_q != REPORT);
  assign bus.out_valid = (state_q == REPORT);
  assign bus.out_max   = out_max_q;
  assign bus.out_rises = out_rises_q;
`ifdef MAX_TRACKER_INDEX_EN
  assign bus.out_idx   = out_idx_q;
`endif
  assign state_dbg_o   = state_q;
  assign accept        = bus.in_valid & bus.in_ready;

  // Next-state and datapath updates; report registers are captured on entry to REPORT.
  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    cnt_d       = cnt_q;
    rises_d     = rises_q;
    out_max_d   = out_max_q;
    out_rises_d = out_rises_q;
`ifdef MAX_TRACKER_INDEX_EN
    idx_d       = idx_q;
    out_idx_d   = out_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          max_d   = bus.in_data;
          cnt_d   = CNT_W'(1);
          rises_d = '0;
`ifdef MAX_TRACKER_INDEX_EN
          idx_d   = '0;
`endif
          state_d = (WINDOW == 1) ? REPORT : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (gt) begin
            max_d   = bus.in_data;
            rises_d = rises_q + CNT_W'(1);
`ifdef MAX_TRACKER_INDEX_EN
            idx_d   = cnt_q;
`endif
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(WINDOW)) state_d = REPORT;
        end
      end
      REPORT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
          rises_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == REPORT) && (state_q != REPORT)) begin
      out_max_d   = max_d;
      out_rises_d = rises_d;
`ifdef MAX_TRACKER_INDEX_EN
      out_idx_d   = idx_d;
`endif
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      max_q       <= '0;
      cnt_q       <= '0;
      rises_q     <= '0;
      out_max_q   <= '0;
      out_rises_q <= '0;
`ifdef MAX_TRACKER_INDEX_EN
      idx_q       <= '0;
      out_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      cnt_q       <= cnt_d;
      rises_q     <= rises_d;
      out_max_q   <= out_max_d;
      out_rises_q <= out_rises_d;
`ifdef MAX_TRACKER_INDEX_EN
      idx_q       <= idx_d;
      out_idx_q   <= out_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_max_tracker_2b.sv
// Directed bench for max_tracker_2b: a WINDOW=4 instance and a WINDOW=1 instance.
module tb_max_tracker_2b;

  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [1:0] st4;
  logic [1:0] st1;

  max_tracker_2b_if #(.CNT_W(CNT_W)) if4 ();
  max_tracker_2b_if #(.CNT_W(CNT_W)) if1 ();

  max_tracker_2b #(.WINDOW(4), .CNT_W(CNT_W)) dut4 (
    .clk(clk), .rst(rst), .bus(if4), .state_dbg_o(st4)
  );

  max_tracker_2b #(.WINDOW(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .state_dbg_o(st1)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample on the WINDOW=4 instance and take the edge.
  task automatic send4(input logic [1:0] s);
    if4.in_valid = 1'b1;
    if4.in_data  = s;
    step();
    if4.in_valid = 1'b0;
  endtask

  // Send a back-to-back window and check the report.
  task automatic window4(input string tag,
                         input logic [1:0] s0, input logic [1:0] s1,
                         input logic [1:0] s2, input logic [1:0] s3,
                         input logic [1:0] exp_max, input logic [3:0] exp_rises,
                         input logic [3:0] exp_idx);
    send4(s0);
    send4(s1);
    send4(s2);
    check({tag, "_pre_valid"}, 32'(if4.out_valid), 32'd0);
    send4(s3);
    check({tag, "_valid"}, 32'(if4.out_valid), 32'd1);
    check({tag, "_in_ready"}, 32'(if4.in_ready), 32'd0);
    check({tag, "_max"}, 32'(if4.out_max), 32'(exp_max));
    check({tag, "_rises"}, 32'(if4.out_rises), 32'(exp_rises));
`ifdef MAX_TRACKER_INDEX_EN
    check({tag, "_idx"}, 32'(if4.out_idx), 32'(exp_idx));
`else
    if (exp_idx == 4'hf) $display("unused idx");
`endif
  endtask

  task automatic drain4(input string tag);
    if4.out_ready = 1'b1;
    step();
    if4.out_ready = 1'b0;
    check({tag, "_drain_valid"}, 32'(if4.out_valid), 32'd0);
    check({tag, "_drain_ready"}, 32'(if4.in_ready), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if4.in_valid = 1'b0; if4.in_data = 2'd0; if4.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = 2'd0; if1.out_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_state", 32'(st4), 32'd0);
    check("rst_out_valid", 32'(if4.out_valid), 32'd0);
    check("rst_in_ready", 32'(if4.in_ready), 32'd1);
    check("rst_out_max", 32'(if4.out_max), 32'd0);
    check("rst_out_rises", 32'(if4.out_rises), 32'd0);
    rst = 1'b0;
    step();

    // Mixed pattern with a tie at the end
    window4("w1", 2'd1, 2'd3, 2'd2, 2'd3, 2'd3, 4'd1, 4'd1);
    drain4("w1");

    // Monotonic rise; then hold the report under backpressure
    window4("w2", 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 4'd3, 4'd3);
    if4.in_valid = 1'b1;
    if4.in_data  = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_in_ready", 32'(if4.in_ready), 32'd0);
      check("bp_out_valid", 32'(if4.out_valid), 32'd1);
      check("bp_out_max", 32'(if4.out_max), 32'd3);
      check("bp_out_rises", 32'(if4.out_rises), 32'd3);
    end
    if4.in_valid = 1'b0;
    drain4("w2");

    // All ties: nothing counted, so no stray sample was consumed during backpressure
    window4("w3", 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 4'd0, 4'd0);
    drain4("w3");

    // Gapped input
    send4(2'd2);
    step(); step(); step();
    check("gap_state", 32'(st4), 32'd1);
    send4(2'd0);
    send4(2'd1);
    check("gap_pre_valid", 32'(if4.out_valid), 32'd0);
    send4(2'd3);
    check("gap_valid", 32'(if4.out_valid), 32'd1);
    check("gap_max", 32'(if4.out_max), 32'd3);
    check("gap_rises", 32'(if4.out_rises), 32'd1);
`ifdef MAX_TRACKER_INDEX_EN
    check("gap_idx", 32'(if4.out_idx), 32'd3);
`endif
    drain4("gap");

    // Reset mid-window discards the partial window
    send4(2'd3);
    send4(2'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_state", 32'(st4), 32'd0);
    check("midrst_out_max", 32'(if4.out_max), 32'd0);
    window4("w4", 2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 4'd2, 4'd3);
    drain4("w4");

    // WINDOW=1: alternating accept / report cycles
    if1.out_ready = 1'b1;
    if1.in_valid  = 1'b1;
    if1.in_data   = 2'd2;
    step();
    check("w1x_a_valid", 32'(if1.out_valid), 32'd1);
    check("w1x_a_in_ready", 32'(if1.in_ready), 32'd0);
    check("w1x_a_max", 32'(if1.out_max), 32'd2);
    check("w1x_a_rises", 32'(if1.out_rises), 32'd0);
    if1.in_data = 2'd1;
    step();
    check("w1x_b_valid", 32'(if1.out_valid), 32'd0);
    check("w1x_b_in_ready", 32'(if1.in_ready), 32'd1);
    step();
    check("w1x_c_valid", 32'(if1.out_valid), 32'd1);
    check("w1x_c_max", 32'(if1.out_max), 32'd1);
    check("w1x_c_rises", 32'(if1.out_rises), 32'd0);
    if1.in_valid = 1'b0;
    step();
    check("w1x_d_valid", 32'(if1.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_tracker_2b.md
Name: max_tracker_2b

Overview:
Sequential stage that sits directly upstream of the 2-bit greater-than comparator logic. It streams 2-bit samples, keeps a registered running maximum, and feeds each new sample and the stored maximum into the comparator equation to decide updates. After a fixed window of samples it reports the maximum and the number of strict rises on a valid/ready output, then restarts.

Parameters:
WINDOW, 4, samples per report window; legal range 1..(2^CNT_W - 1)
CNT_W, 4, width of the sample counter and rise counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  sample on in_data is valid
in_ready  output  1  block accepts a sample this cycle
in_data  input  2  sample; bit1 = A (MSB), bit0 = B (LSB)
out_valid  output  1  report available
out_ready  input  1  consumer takes the report
out_max  output  2  maximum of the window
out_rises  output  CNT_W  number of samples strictly greater than the running max at their arrival (first sample excluded)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, max=0, cnt=0, rises=0, out_valid=0, out_max=0, out_rises=0. Reset takes effect in any state and discards a partial window or pending report.
- Sample accepted when in_valid & in_ready at posedge.
- Comparison is strictly greater, using the existing 2-bit equation: gt = A·~C + A·B·~D + B·~C·~D, with A,B = in_data[1:0] and C,D = max[1:0]. Ties do not update and do not count.
- States:
  - IDLE: in_ready=1, out_valid=0. On accept: max<=in_data, cnt<=1, rises<=0. If WINDOW==1 go to REPORT, otherwise go to ACCUM.
  - ACCUM: in_ready=1. On accept: if gt then max<=in_data and rises<=rises+1. cnt<=cnt+1. If cnt+1==WINDOW go to REPORT. With no accept, hold all state.
  - REPORT: in_ready=0, out_valid=1. out_max and out_rises are loaded on entry and held stable while out_ready=0. On out_ready=1, go to IDLE and clear cnt and rises. in_data/in_valid are ignored in this state.
- Latency: out_valid rises on the cycle after the final sample of the window is accepted.
- Throughput: one sample per cycle in IDLE/ACCUM. The minimum gap between windows is the single REPORT handshake cycle.
- Counters never wrap, because rises ≤ WINDOW-1 and cnt ≤ WINDOW < 2^CNT_W.
- out_valid is not combinationally dependent on out_ready. in_ready depends only on state.

Optional Feature:
Macro MAX_TRACKER_INDEX_EN.
- Defined:
  - Adds output out_idx [CNT_W-1:0]: the 0-based position within the window of the first occurrence of the maximum.
  - out_idx resets to 0 and is set to 0 on the first sample.
  - On a strict update it takes the value of cnt, i.e. the position of the sample being accepted.
  - It is held with out_max during REPORT.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- WINDOW=4, samples 1,3,2,3 back-to-back -> out_valid one cycle after 4th accept; out_max=3, out_rises=1, out_idx=1 (with INDEX_EN).
- Samples 0,1,2,3 -> out_max=3, out_rises=3, out_idx=3. Samples 2,2,2,2 -> out_max=2, out_rises=0, out_idx=0 (ties ignored).
- Backpressure: complete a window, hold out_ready=0 for 5 cycles while driving in_valid=1, in_data=3 -> in_ready=0, out_valid=1, outputs stable, no sample consumed. Then out_ready=1 -> IDLE next cycle.
- Gapped input: samples 2,(in_valid=0 ×3),0,1,3 -> same result as back-to-back: out_max=3, out_rises=1.
- Reset mid-window: accept 3,3, assert rst one cycle, then send 0,1,0,2 -> out_max=2, out_rises=2, no trace of the earlier 3.
- WINDOW=1: each accepted sample produces a report with out_max=sample and out_rises=0, in alternating accept/REPORT cycles.
